// File: rtl/plic_core_if.sv
// Bus bundle between the PLIC core and the CPU/board side: source lines, config, claim/complete.
// Carries edge_mode only when PLIC_EDGE_EN is defined.
`timescale 1ns/1ps
interface plic_core_if #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(N_SRC + 1)
);
    logic [N_SRC-1:0]  irq_src;
    logic [N_SRC-1:0]  irq_en;
    logic [PRIO_W-1:0] threshold;
    logic              prio_we;
    logic [ID_W-1:0]   prio_idx;
    logic [PRIO_W-1:0] prio_wdata;
    logic              claim_req;
    logic              claim_valid;
    logic [ID_W-1:0]   claim_id;
    logic              complete_req;
    logic [ID_W-1:0]   complete_id;
    logic              irq_out;
    logic [N_SRC-1:0]  pending_o;
`ifdef PLIC_EDGE_EN
    logic [N_SRC-1:0]  edge_mode;
`endif

    modport master (
`ifdef PLIC_EDGE_EN
        output edge_mode,
`endif
        output irq_src, irq_en, threshold, prio_we, prio_idx, prio_wdata,
        output claim_req, complete_req, complete_id,
        input  claim_valid, claim_id, irq_out, pending_o
    );

    modport slave (
`ifdef PLIC_EDGE_EN
        input  edge_mode,
`endif
        input  irq_src, irq_en, threshold, prio_we, prio_idx, prio_wdata,
        input  claim_req, complete_req, complete_id,
        output claim_valid, claim_id, irq_out, pending_o
    );
endinterface

// File: rtl/plic_core.sv
// Parametrised platform-level interrupt controller core: synchroniser, per-source gateways,
// priority/enable/threshold filtering, registered arbitration. PLIC_EDGE_EN adds edge triggering.
`timescale 1ns/1ps
module plic_core #(
    parameter int N_SRC       = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(N_SRC + 1)
) (
    input logic        CLK100MHZ,
    input logic        CPU_RESETN,
    plic_core_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_INFLIGHT} gw_state_e;

    logic [N_SRC-1:0]  sync_src;
    logic [N_SRC-1:0]  trig;
    logic [N_SRC-1:0]  pend;
    logic [N_SRC-1:0]  claim_hit;
    logic [N_SRC-1:0]  complete_hit;
    logic [N_SRC-1:0]  eligible;
    gw_state_e         state_q [N_SRC];
    logic [PRIO_W-1:0] prio_q  [N_SRC];
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id_d;
    logic [ID_W-1:0]   best_id_q;
    logic [ID_W-1:0]   claim_id_q;
    logic              claim_valid_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_src = bus.irq_src;
        end else begin : g_sync
            logic [N_SRC-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
                if (CPU_RESETN) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= bus.irq_src;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign sync_src = sync_q[SYNC_STAGES-1];
        end
    endgenerate

`ifdef PLIC_EDGE_EN
    logic [N_SRC-1:0] hist_q;
    logic [N_SRC-1:0] edge_q;
    logic [N_SRC-1:0] rise;

    assign rise = sync_src & ~hist_q & bus.edge_mode;
    assign trig = (bus.edge_mode & (edge_q | rise)) | (~bus.edge_mode & sync_src);

    // One remembered edge per source; it is consumed only when an idle gateway goes pending.
    always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            hist_q <= '0;
            edge_q <= '0;
        end else begin
            hist_q <= sync_src;
            for (int i = 0; i < N_SRC; i++) begin
                if (state_q[i] == S_IDLE && bus.edge_mode[i] && trig[i]) edge_q[i] <= 1'b0;
                else                                                      edge_q[i] <= edge_q[i] | rise[i];
            end
        end
    end
`else
    assign trig = sync_src;
`endif

    // A claim masks the source it is taking so the arbiter never offers it twice.
    always_comb begin
        pend         = '0;
        claim_hit    = '0;
        complete_hit = '0;
        eligible     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend[i]         = (state_q[i] == S_PENDING);
            claim_hit[i]    = bus.claim_req && (best_id_q == ID_W'(i + 1));
            complete_hit[i] = bus.complete_req && (bus.complete_id == ID_W'(i + 1));
            eligible[i]     = pend[i] && bus.irq_en[i] && (prio_q[i] > bus.threshold) && !claim_hit[i];
        end
    end

    always_comb begin
        best_id_d = '0;
        best_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (best_id_d == '0 || prio_q[i] > best_prio)) begin
                best_id_d = ID_W'(i + 1);
                best_prio = prio_q[i];
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            for (int i = 0; i < N_SRC; i++) state_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                case (state_q[i])
                    S_IDLE:     if (trig[i])         state_q[i] <= S_PENDING;
                    S_PENDING:  if (claim_hit[i])    state_q[i] <= S_INFLIGHT;
                    S_INFLIGHT: if (complete_hit[i]) state_q[i] <= S_IDLE;
                    default:                         state_q[i] <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
        end else if (bus.prio_we) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (bus.prio_idx == ID_W'(i + 1)) prio_q[i] <= bus.prio_wdata;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            best_id_q     <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            best_id_q     <= best_id_d;
            claim_valid_q <= bus.claim_req;
            claim_id_q    <= bus.claim_req ? best_id_q : '0;
        end
    end

    assign bus.irq_out     = (best_id_q != '0);
    assign bus.claim_valid = claim_valid_q;
    assign bus.claim_id    = claim_id_q;
    assign bus.pending_o   = pend;
endmodule

// File: tb/tb_plic_core.sv
// Directed bench for plic_core: claim responses go through an expected-ID queue checked by a
// monitor; steady-state outputs are checked inline.
`timescale 1ns/1ps
module tb_plic_core;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] expQ [$];
    logic [3:0] expId;

    always #5 clk = ~clk;

    plic_core_if bus ();

    plic_core dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst),
        .bus        (bus)
    );

    // Every claim_valid pulse must match the oldest expected claim ID.
    always @(negedge clk) begin
        if (bus.claim_valid === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL stray_claim: got id %0d, none expected", bus.claim_id);
            end else begin
                expId = expQ.pop_front();
                if (bus.claim_id !== expId) begin
                    errors++;
                    $display("[TB] FAIL claim_id: got %0d, expected %0d", bus.claim_id, expId);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] en, input logic [2:0] thr);
        bus.irq_src   = src;
        bus.irq_en    = en;
        bus.threshold = thr;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic writePrio(input int idx, input int val);
        bus.prio_we    = 1'b1;
        bus.prio_idx   = 4'(idx);
        bus.prio_wdata = 3'(val);
        tick(1);
        bus.prio_we    = 1'b0;
    endtask

    task automatic issueClaim(input int expected);
        expQ.push_back(4'(expected));
        bus.claim_req = 1'b1;
        tick(1);
        bus.claim_req = 1'b0;
        tick(1);
    endtask

    task automatic issueComplete(input int id);
        bus.complete_req = 1'b1;
        bus.complete_id  = 4'(id);
        tick(1);
        bus.complete_req = 1'b0;
        bus.complete_id  = '0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.prio_we      = 1'b0;
        bus.prio_idx     = '0;
        bus.prio_wdata   = '0;
        bus.claim_req    = 1'b0;
        bus.complete_req = 1'b0;
        bus.complete_id  = '0;
`ifdef PLIC_EDGE_EN
        bus.edge_mode    = '0;
`endif
        applyStimulus(8'hFF, 8'hFF, 3'd0);
        tick(3);
        checkOutput("reset_irq_out", 64'(bus.irq_out), 64'd0);
        checkOutput("reset_pending", 64'(bus.pending_o), 64'h00);
        checkOutput("reset_claim_id", 64'(bus.claim_id), 64'd0);
        checkOutput("reset_claim_valid", 64'(bus.claim_valid), 64'd0);
        rst = 1'b0;
        tick(6);
        checkOutput("prio0_no_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("prio0_pending", 64'(bus.pending_o), 64'hFF);

        applyStimulus(8'h00, 8'hFF, 3'd0);
        resetDut();
        writePrio(3, 5);
        writePrio(6, 5);
        writePrio(2, 7);
        applyStimulus(8'h26, 8'hFF, 3'd0);
        tick(6);
        checkOutput("arb_irq_out", 64'(bus.irq_out), 64'd1);
        checkOutput("arb_pending", 64'(bus.pending_o), 64'h26);
        issueClaim(2);
        issueClaim(3);
        issueClaim(6);
        checkOutput("arb_drained_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("arb_drained_pending", 64'(bus.pending_o), 64'h00);
        applyStimulus(8'h00, 8'hFF, 3'd0);
        tick(4);
        issueComplete(2);
        issueComplete(3);
        issueComplete(6);
        tick(3);
        checkOutput("completed_pending", 64'(bus.pending_o), 64'h00);
        checkOutput("completed_irq", 64'(bus.irq_out), 64'd0);

        writePrio(4, 3);
        applyStimulus(8'h08, 8'hFF, 3'd3);
        tick(6);
        checkOutput("thr_equal_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("thr_equal_pending", 64'(bus.pending_o), 64'h08);
        applyStimulus(8'h08, 8'hFF, 3'd2);
        tick(2);
        checkOutput("thr_below_irq", 64'(bus.irq_out), 64'd1);
        applyStimulus(8'h08, 8'hF7, 3'd2);
        tick(2);
        checkOutput("masked_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("masked_pending", 64'(bus.pending_o), 64'h08);

        applyStimulus(8'h08, 8'hFF, 3'd2);
        tick(2);
        issueClaim(4);
        checkOutput("inflight_pending", 64'(bus.pending_o), 64'h00);
        issueComplete(5);
        tick(2);
        checkOutput("wrong_complete_pending", 64'(bus.pending_o), 64'h00);
        issueComplete(4);
        tick(1);
        checkOutput("repend_pending", 64'(bus.pending_o), 64'h08);

        applyStimulus(8'h08, 8'hFF, 3'd7);
        tick(2);
        issueClaim(0);
        checkOutput("empty_claim_pending", 64'(bus.pending_o), 64'h08);

        applyStimulus(8'h0A, 8'hFF, 3'd0);
        tick(6);
        issueClaim(2);
        checkOutput("mid_pending", 64'(bus.pending_o), 64'h08);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_pending", 64'(bus.pending_o), 64'h00);
        checkOutput("async_rst_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("async_rst_claim_id", 64'(bus.claim_id), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(6);
        checkOutput("post_rst_irq", 64'(bus.irq_out), 64'd0);
        checkOutput("post_rst_pending", 64'(bus.pending_o), 64'h0A);

`ifdef PLIC_EDGE_EN
        applyStimulus(8'h00, 8'hFF, 3'd0);
        resetDut();
        writePrio(1, 1);
        bus.edge_mode = 8'h01;
        tick(4);
        bus.irq_src = 8'h01;
        tick(1);
        bus.irq_src = 8'h00;
        tick(5);
        checkOutput("edge_pending", 64'(bus.pending_o), 64'h01);
        issueClaim(1);
        checkOutput("edge_inflight", 64'(bus.pending_o), 64'h00);
        bus.irq_src = 8'h01;
        tick(1);
        bus.irq_src = 8'h00;
        tick(5);
        checkOutput("edge_latched_hidden", 64'(bus.pending_o), 64'h00);
        issueComplete(1);
        tick(1);
        checkOutput("edge_latched_repend", 64'(bus.pending_o), 64'h01);
`endif

        for (int n = 0; n < 20 && expQ.size() != 0; n++) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/plic_core.md
Name: plic_core

Overview:
- Parametrised platform-level interrupt controller core; sits inside the board wrapper between the synchronised switch/peripheral interrupt lines and the CPU claim/complete interface.
- Generalises the fixed-channel lab controller:
  - N_SRC sources;
  - per-source priority registers;
  - enable mask and threshold;
  - per-source gateway state machine;
  - registered highest-priority arbitration.
- Source bit i is interrupt ID i+1; ID 0 means "no interrupt".

Parameters:
- N_SRC, 8, number of interrupt sources (1..63).
- PRIO_W, 3, priority width; priority 0 = never interrupts.
- SYNC_STAGES, 2, flip-flop synchroniser depth on irq_src (0 = no synchroniser).
- ID_W, $clog2(N_SRC+1), interrupt ID width (derived; do not override).

Ports:
- CLK100MHZ, input, 1: system clock.
- CPU_RESETN, input, 1: reset, asynchronous, active-high (asserted = 1, despite the name).
- irq_src, input, N_SRC: raw interrupt request lines, level-sensitive.
- irq_en, input, N_SRC: per-source enable mask.
- threshold, input, PRIO_W: interrupt only if priority > threshold.
- prio_we, input, 1: priority write strobe.
- prio_idx, input, ID_W: ID whose priority is written; 0 or >N_SRC is ignored.
- prio_wdata, input, PRIO_W: priority value.
- claim_req, input, 1: one-cycle claim pulse from the CPU.
- claim_valid, output, 1: one-cycle pulse, claim_id is valid.
- claim_id, output, ID_W: claimed ID; 0 if nothing is eligible.
- complete_req, input, 1: one-cycle completion pulse.
- complete_id, input, ID_W: ID being completed.
- irq_out, output, 1: interrupt request to the CPU.
- pending_o, output, N_SRC: pending bits, for LED debug.

Behaviour:
- Reset: async, active-high. While asserted, all outputs are 0; all priorities, pending bits, inflight bits and synchroniser flops are 0. After release, operation resumes at the next rising edge.
- Synchroniser: irq_src passes through SYNC_STAGES flops per bit, giving sync_src.
- Gateway FSM (one per source): IDLE, PENDING, INFLIGHT.
  - IDLE -> PENDING when sync_src[i]=1.
  - PENDING -> INFLIGHT when source i is selected by a claim.
  - INFLIGHT -> IDLE on a valid complete for ID i+1. The gateway ignores the line while INFLIGHT.
  - pending_o[i] = (state==PENDING).
- Eligibility: PENDING, irq_en[i]=1, prio[i] > threshold. Disabling a PENDING source does not clear it; it stays pending but ineligible.
- Arbitration:
  - Combinational over the registered state.
  - Highest priority wins; ties go to the lowest ID.
  - The result (best_id, best_prio) is registered every cycle.
  - irq_out = registered (best_id != 0), so there is 1 cycle of latency from a state change to irq_out.
- Claim:
  - claim_req at edge k causes claim_valid=1 and claim_id=best_id (registered value) at edge k+1.
  - At that edge the selected gateway moves to INFLIGHT. Without this update, irq_out would reflect the claimed source for one stale cycle; it is recomputed the following cycle.
  - If best_id=0: claim_id=0, claim_valid=1, no state change.
- Complete:
  - complete_req with an ID in 1..N_SRC whose gateway is INFLIGHT moves it to IDLE.
  - ID 0, an out-of-range ID, or a non-INFLIGHT gateway: ignored.
- Simultaneous events:
  - Claim and complete in the same cycle are both applied.
  - Complete of ID x, with the line still high, re-enters PENDING no earlier than the next cycle.
  - A priority write in the same cycle as a claim takes effect for arbitration next cycle.
- Priority register writes take effect at the next edge.

Optional Feature:
- Macro: PLIC_EDGE_EN.
- When defined:
  - Adds input edge_mode [N_SRC]. With edge_mode[i]=1, source i is edge-triggered: a rising edge of sync_src[i] sets a per-source edge latch.
  - IDLE -> PENDING consumes the latch.
  - Edges arriving while PENDING or INFLIGHT are latched (at most one is remembered). This requires one extra history flop per source.
- When undefined: the port, latches and history flops are absent; all sources are level-triggered.

Test Plan:
- Reset: CPU_RESETN=1 with irq_src=8'hFF -> irq_out=0, claim_id=0, pending_o=0. Release reset -> nothing fires, because all priorities are 0.
- Arbitration: prio[3]=5, prio[6]=5, prio[2]=7, all enabled, threshold=0. Raise sources 2,5,1 (IDs 3,6,2) -> irq_out=1.
  - Claims return ID 2, then 3, then 6.
  - After the third claim, irq_out=0 within 2 cycles.
- Threshold and mask:
  - prio[4]=3, threshold=3 -> irq_out=0; threshold=2 -> irq_out=1 two cycles later.
  - Clear irq_en[3] -> irq_out=0, pending_o[3] stays 1.
- Gateway:
  - Claim ID 4 with the line held high -> pending_o[3]=0.
  - complete_id=5 -> ignored; complete_id=4 -> pending_o[3]=1 again within 2 cycles.
- Empty claim and reset mid-operation:
  - claim with nothing pending -> claim_valid=1, claim_id=0.
  - Assert reset while ID 2 is INFLIGHT -> all state cleared immediately, without waiting for a clock edge.
- PLIC_EDGE_EN: edge_mode[0]=1, pulse irq_src[0] for 1 cycle (SYNC_STAGES=2) -> pending_o[0]=1.
  - A second pulse during INFLIGHT, then complete 1 -> pending_o[0]=1 again with no further edge.
